// File: rtl/counter_updown_param_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_CLAMP,
        ACT_STEP
    } act_e;

    // Prescaler width: wide enough to hold DIV_SLOW-1 for any DIV_SLOW >= 1.
    function automatic int unsigned calc_pw(input int unsigned div_slow);
        return $clog2(div_slow + 1);
    endfunction

endpackage

// File: rtl/counter_updown_param_if.sv
// Control/status bundle between the counter and its user logic.
interface counter_updown_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic             speed;
    logic             UD;
    logic             SS;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic             sat;
    logic [WIDTH-1:0] out;
    logic             tc;

    modport master (
        output speed, UD, SS, load, load_val, max_val, sat,
        input  out, tc
    );

    modport slave (
        input  speed, UD, SS, load, load_val, max_val, sat,
        output out, tc
    );
endinterface

// File: rtl/counter_updown_param_tick_gen.sv
// Two-rate prescaler producing a single-cycle count-enable tick.
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned DIV_SLOW = 8,
    parameter int unsigned DIV_FAST = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic speed,
    output logic tick
);
    localparam int unsigned       PW       = calc_pw(DIV_SLOW);
    localparam logic [PW-1:0]     LIM_SLOW = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0]     LIM_FAST = PW'(DIV_FAST - 1);

    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_lim;

    // ">=" lets a slow-to-fast switch mid-period tick at once instead of overshooting.
    always_comb begin
        w_lim = speed ? LIM_FAST : LIM_SLOW;
        tick  = en & (r_presc >= w_lim);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (clr) begin
            r_presc <= '0;
        end else if (en) begin
            if (tick) r_presc <= '0;
            else      r_presc <= r_presc + PW'(1);
        end
    end
endmodule

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with runtime limit, load, wrap/saturate and terminal-count pulse.
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIV_SLOW = 8,
    parameter int unsigned DIV_FAST = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_updown_param_if.slave bus
);
    logic             w_tick;
    logic             w_en;
    act_e             w_act;
    logic [WIDTH-1:0] w_load_lim;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;

    assign w_en = bus.SS & ~bus.load;

    tick_gen #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (bus.load),
        .speed (bus.speed),
        .tick  (w_tick)
    );

    always_comb begin
        w_act = ACT_HOLD;
        if (bus.load)                      w_act = ACT_LOAD;
        else if (w_tick && r_out > bus.max_val) w_act = ACT_CLAMP;
        else if (w_tick)                   w_act = ACT_STEP;
    end

    always_comb begin
        w_load_lim = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
        w_out_nxt  = r_out;
        w_tc_nxt   = 1'b0;
        case (w_act)
            ACT_LOAD:  w_out_nxt = w_load_lim;
            ACT_CLAMP: w_out_nxt = bus.max_val;
            ACT_STEP: begin
                if (bus.UD == DIR_UP) begin
                    if (r_out == bus.max_val) begin
                        w_tc_nxt  = 1'b1;
                        w_out_nxt = (bus.sat == MODE_SAT) ? bus.max_val : '0;
                    end else begin
                        w_out_nxt = r_out + WIDTH'(1);
                    end
                end else begin
                    if (r_out == '0) begin
                        w_tc_nxt  = 1'b1;
                        w_out_nxt = (bus.sat == MODE_SAT) ? '0 : bus.max_val;
                    end else begin
                        w_out_nxt = r_out - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
            r_tc  <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            r_tc  <= w_tc_nxt;
        end
    end

    assign bus.out = r_out;
    assign bus.tc  = r_tc;
endmodule

// File: tb/tb_counter_updown_param.sv
// Directed checks of counter_updown_param with WIDTH=8, DIV_SLOW=4, DIV_FAST=2.
module tb_counter_updown_param;
    localparam int unsigned WIDTH = 8;
    localparam int NV = 21;

    typedef struct packed {
        logic       load;
        logic [7:0] lv;
        logic [7:0] mx;
        logic       sat;
        logic       ud;
        logic       ss;
        logic       spd;
        logic [7:0] cyc;
        logic [7:0] eout;
        logic       etc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    counter_updown_param_if #(.WIDTH(WIDTH)) bus ();

    counter_updown_param #(
        .WIDTH    (WIDTH),
        .DIV_SLOW (4),
        .DIV_FAST (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic load, input int lv, input int mx, input logic sat,
                                input logic ud, input logic ss, input logic spd, input int cyc,
                                input int eout, input logic etc);
        vec_t v;
        v.load = load; v.lv = 8'(lv); v.mx = 8'(mx); v.sat = sat; v.ud = ud;
        v.ss = ss; v.spd = spd; v.cyc = 8'(cyc); v.eout = 8'(eout); v.etc = etc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_both(input string nm, input int idx, input int eout, input logic etc);
        chk({nm, "_out"}, idx, bus.out, 8'(eout));
        chk({nm, "_tc"},  idx, {7'd0, bus.tc}, {7'd0, etc});
    endtask

    initial begin
        //      load lv  max sat ud ss spd cyc out tc
        vecs[0]  = mk(0,   0, 255, 0, 1, 1, 0, 3,   0, 0);
        vecs[1]  = mk(0,   0, 255, 0, 1, 1, 0, 1,   1, 0);
        vecs[2]  = mk(0,   0, 255, 0, 1, 1, 0, 4,   2, 0);
        vecs[3]  = mk(0,   0, 255, 0, 1, 1, 0, 4,   3, 0);
        vecs[4]  = mk(1, 254, 255, 0, 1, 1, 1, 1, 254, 0);
        vecs[5]  = mk(0,   0, 255, 0, 1, 1, 1, 2, 255, 0);
        vecs[6]  = mk(0,   0, 255, 0, 1, 1, 1, 2,   0, 1);
        vecs[7]  = mk(0,   0, 255, 0, 1, 1, 1, 1,   0, 0);
        vecs[8]  = mk(0,   0, 255, 0, 0, 1, 1, 1, 255, 1);
        vecs[9]  = mk(0,   0, 255, 0, 0, 1, 1, 1, 255, 0);
        vecs[10] = mk(0,   0, 255, 0, 0, 1, 1, 1, 254, 0);
        vecs[11] = mk(1,   8,   9, 1, 1, 1, 1, 1,   8, 0);
        vecs[12] = mk(0,   0,   9, 1, 1, 1, 1, 2,   9, 0);
        vecs[13] = mk(0,   0,   9, 1, 1, 1, 1, 2,   9, 1);
        vecs[14] = mk(0,   0,   9, 1, 1, 1, 1, 1,   9, 0);
        vecs[15] = mk(0,   0,   9, 1, 1, 1, 1, 1,   9, 1);
        vecs[16] = mk(0,   0,   9, 0, 1, 1, 1, 1,   9, 0);
        vecs[17] = mk(0,   0,   9, 0, 1, 1, 1, 1,   0, 1);
        vecs[18] = mk(1,   5,   0, 0, 1, 1, 1, 1,   0, 0);
        vecs[19] = mk(0,   0,   0, 0, 1, 1, 1, 2,   0, 1);
        vecs[20] = mk(0,   0,   0, 1, 0, 1, 1, 2,   0, 1);

        bus.load = 1'b0; bus.load_val = '0; bus.max_val = 8'd255; bus.sat = 1'b0;
        bus.UD = 1'b1; bus.SS = 1'b1; bus.speed = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_both("reset_hold", i, 0, 1'b0);
        end
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.load = vecs[i].load; bus.load_val = vecs[i].lv; bus.max_val = vecs[i].mx;
            bus.sat = vecs[i].sat; bus.UD = vecs[i].ud; bus.SS = vecs[i].ss;
            bus.speed = vecs[i].spd;
            repeat (int'(vecs[i].cyc)) @(negedge clk);
            chk_both("vec", i, int'(vecs[i].eout), vecs[i].etc);
        end

        // Stop mid-period at presc=2, then resume at fast rate
        bus.load = 1'b1; bus.load_val = 8'd10; bus.max_val = 8'd255; bus.sat = 1'b0;
        bus.UD = 1'b1; bus.SS = 1'b1; bus.speed = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        chk_both("pre_stop", 0, 10, 1'b0);
        bus.SS = 1'b0;
        repeat (10) @(negedge clk);
        chk_both("stopped", 0, 10, 1'b0);
        bus.SS = 1'b1; bus.speed = 1'b1;
        @(negedge clk);
        chk_both("resume", 0, 11, 1'b0);
        @(negedge clk);
        chk_both("resume", 1, 11, 1'b0);
        @(negedge clk);
        chk_both("resume", 2, 12, 1'b0);

        // Load beats a due tick, then clamp after lowering max_val
        bus.max_val = 8'd100;
        @(negedge clk);
        chk_both("pre_load", 0, 12, 1'b0);
        bus.load = 1'b1; bus.load_val = 8'd200;
        @(negedge clk);
        chk_both("load_clip", 0, 100, 1'b0);
        bus.load = 1'b0; bus.max_val = 8'd50;
        @(negedge clk);
        chk_both("post_load", 0, 100, 1'b0);
        @(negedge clk);
        chk_both("clamp", 0, 50, 1'b0);
        bus.sat = 1'b1;
        repeat (2) @(negedge clk);
        chk_both("sat_top", 0, 50, 1'b1);

        // Asynchronous reset between clock edges
        #2 reset = 1'b0;
        #1 chk_both("async_rst", 0, 0, 1'b0);
        @(negedge clk);
        chk_both("async_rst", 1, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_both("post_rst", 0, 0, 1'b0);
        @(negedge clk);
        chk_both("post_rst", 1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
